// File: rtl/axis_fifo_split_pkg.sv
// axis_fifo_split_pkg: state encodings and slice widths shared by the AXIS double/split pair
package axis_fifo_split_pkg;
  localparam int W = 512;
  localparam int KEEP_W = W / 8;
  localparam int DW2 = 2 * W;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2
  } state_t;
endpackage

// File: rtl/axis_fifo_split.sv
// axis_fifo_split: splits one 2W AXIS double beat into two W beats, lower half first
// aclk/reset: clock, sync active-high reset; in_*: 2W-wide AXIS slave; out_*: W-wide AXIS master
module axis_fifo_split
  import axis_fifo_split_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256
) (
  input  logic                          aclk,
  input  logic                          reset,
  input  logic [2*AXIS_DATA_WIDTH-1:0]  in_tdata,
  input  logic [AXIS_DATA_WIDTH/4-1:0]  in_tkeep,
  input  logic [2*AXIS_TUSER_WIDTH-1:0] in_tuser,
  input  logic                          in_tlast,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  output logic [AXIS_DATA_WIDTH-1:0]    out_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  out_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   out_tuser,
  output logic                          out_tlast,
  output logic                          out_tvalid,
  input  logic                          out_tready
);
  localparam int DW = AXIS_DATA_WIDTH;
  localparam int KW = AXIS_DATA_WIDTH / 8;
  localparam int UW = AXIS_TUSER_WIDTH;
  state_t              r_state, w_next;
  logic [2*DW-1:0]     r_data;
  logic [2*KW-1:0]     r_keep;
  logic [2*UW-1:0]     r_user;
  logic                r_last;
  logic                w_skip_hi, w_final, w_accept, w_hi;
  // odd-length packet: the upper half of the final double beat carries nothing
  assign w_skip_hi  = r_last & (r_keep[2*KW-1:KW] == '0);
  assign w_final    = (r_state == HIGH) | ((r_state == LOW) & w_skip_hi);
  // combinational out_tready -> in_tready so a new double beat loads with no bubble
  assign in_tready  = (r_state == EMPTY) | (out_tready & w_final);
  assign w_accept   = in_tvalid & in_tready;
  assign w_hi       = r_state == HIGH;
  assign out_tvalid = r_state != EMPTY;
  assign out_tdata  = w_hi ? r_data[2*DW-1:DW] : r_data[DW-1:0];
  assign out_tkeep  = w_hi ? r_keep[2*KW-1:KW] : r_keep[KW-1:0];
  assign out_tuser  = w_hi ? r_user[2*UW-1:UW] : r_user[UW-1:0];
  assign out_tlast  = w_hi ? r_last : ((r_state == LOW) & w_skip_hi);
  always_comb begin
    w_next = ((r_state == EMPTY) | (w_final & out_tready)) ? (w_accept ? LOW : EMPTY) :
             (((r_state == LOW) & out_tready) ? HIGH : r_state);
  end
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_keep  <= '0;
      r_user  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data <= in_tdata;
        r_keep <= in_tkeep;
        r_user <= in_tuser;
        r_last <= in_tlast;
      end
    end
  end
endmodule

// File: tb/tb_axis_fifo_split.sv
// tb_axis_fifo_split: scoreboard bench for the AXIS 2:1 width splitter
module tb_axis_fifo_split;
  localparam int W  = 512;
  localparam int KW = W / 8;
  localparam int UW = 256;
  localparam logic [KW-1:0] K1 = '1;
  localparam logic [KW-1:0] K0 = '0;
  typedef struct packed {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    logic          f;
  } beat_t;
  logic            aclk, reset;
  logic [2*W-1:0]  in_tdata;
  logic [2*KW-1:0] in_tkeep;
  logic [2*UW-1:0] in_tuser;
  logic            in_tlast, in_tvalid, in_tready;
  logic [W-1:0]    out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic [UW-1:0]   out_tuser;
  logic            out_tlast, out_tvalid, out_tready;
  beat_t           exp_q[$];
  int              errors = 0;
  int              checks = 0;
  axis_fifo_split #(.AXIS_DATA_WIDTH(W), .AXIS_TUSER_WIDTH(UW)) dut (
    .aclk(aclk), .reset(reset),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser(in_tuser),
    .in_tlast(in_tlast), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tuser(out_tuser),
    .out_tlast(out_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready)
  );
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  always @(negedge aclk) begin : monitor
    beat_t b;
    #2;
    if (!reset && out_tvalid && out_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected beat data=%h last=%b", out_tdata[31:0], out_tlast);
      end else begin
        b = exp_q.pop_front();
        if ({out_tdata, out_tkeep, out_tuser, out_tlast} !== {b.d, b.k, b.u, b.l}) begin
          errors++;
          $display("FAIL beat: got data=%h keep=%h user=%h last=%b, want data=%h keep=%h user=%h last=%b",
                   out_tdata[31:0], out_tkeep, out_tuser[31:0], out_tlast, b.d[31:0], b.k, b.u[31:0], b.l);
        end
      end
    end
  end
  task automatic sync;
    @(posedge aclk);
    #1;
  endtask
  task automatic idle;
    in_tvalid = 1'b0;
  endtask
  task automatic push_db(input logic [31:0] lo, input logic [31:0] hi,
                         input logic [KW-1:0] klo, input logic [KW-1:0] khi, input logic last);
    beat_t b;
    logic skip, ok;
    int n;
    skip = last && (khi == '0);
    in_tdata  = {{16{hi}}, {16{lo}}};
    in_tkeep  = {khi, klo};
    in_tuser  = {{8{~hi}}, {8{~lo}}};
    in_tlast  = last;
    in_tvalid = 1'b1;
    b.d = {16{lo}}; b.k = klo; b.u = {8{~lo}}; b.l = skip; b.f = skip;
    exp_q.push_back(b);
    if (!skip) begin
      b.d = {16{hi}}; b.k = khi; b.u = {8{~hi}}; b.l = last; b.f = 1'b1;
      exp_q.push_back(b);
    end
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge aclk);
      ok = in_tready;
      @(posedge aclk);
      n++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept: in_tready stayed 0 for lo=%h, want 1 within 200 cycles", lo);
    end
    #1;
  endtask
  task automatic wait_drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge aclk);
      n++;
    end
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 reset = 1'b0;
    @(negedge aclk);
    checks += 3;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_tvalid); end
    if (in_tready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_tready); end
    if (out_tlast !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_tlast); end
    checks += 3;
    if (out_tdata !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_tdata[31:0]); end
    if (out_tkeep !== '0) begin errors++; $display("FAIL reset_keep: got %h want 0", out_tkeep); end
    if (out_tuser !== '0) begin errors++; $display("FAIL reset_user: got %h want 0", out_tuser[31:0]); end
  endtask
  task automatic test_four_beat;
    int cnt = 0;
    sync;
    out_tready = 1'b1;
    fork
      begin
        push_db(32'h11, 32'h22, K1, K1, 1'b0);
        push_db(32'h33, 32'h44, K1, K1, 1'b1);
        idle;
      end
      repeat (12) begin
        @(negedge aclk);
        cnt += int'(out_tvalid);
      end
    join
    wait_drain;
    checks += 2;
    if (cnt != 4) begin errors++; $display("FAIL four_beat_cycles: got %0d valid cycles want 4", cnt); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL four_beat_drain: %0d beats missing want 0", exp_q.size()); end
  endtask
  task automatic test_odd;
    int cnt = 0;
    logic seen = 1'b0;
    sync;
    out_tready = 1'b1;
    fork
      begin
        push_db(32'h11, 32'h22, K1, K1, 1'b0);
        push_db(32'h33, 32'h0, K1, K0, 1'b1);
        idle;
      end
      repeat (12) begin
        @(negedge aclk);
        cnt += int'(out_tvalid);
        if (out_tvalid && out_tdata[31:0] == 32'h33) begin
          seen = 1'b1;
          checks++;
          if (in_tready !== 1'b1 || out_tlast !== 1'b1) begin
            errors++;
            $display("FAIL odd_final: in_tready=%b tlast=%b want 1 1", in_tready, out_tlast);
          end
        end
      end
    join
    wait_drain;
    checks += 3;
    if (!seen) begin errors++; $display("FAIL odd_seen: beat 0x33 got 0 times want 1"); end
    if (cnt != 3) begin errors++; $display("FAIL odd_cycles: got %0d valid cycles want 3", cnt); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL odd_drain: %0d beats missing want 0", exp_q.size()); end
  endtask
  task automatic test_back_to_back;
    int bubbles = 0;
    int n = 0;
    sync;
    out_tready = 1'b1;
    fork
      begin
        push_db(32'h101, 32'h102, K1, K1, 1'b0);
        push_db(32'h103, 32'h104, K1, K1, 1'b1);
        push_db(32'h105, 32'h106, K1, K1, 1'b0);
        push_db(32'h107, 32'h0, K1, K0, 1'b1);
        push_db(32'h108, 32'h109, K1, K1, 1'b1);
        idle;
      end
      begin
        while (!out_tvalid && n < 50) begin @(negedge aclk); n++; end
        while (exp_q.size() > 0 && n < 200) begin
          if (!out_tvalid) bubbles++;
          @(negedge aclk);
          n++;
        end
      end
    join
    wait_drain;
    checks += 2;
    if (bubbles != 0) begin errors++; $display("FAIL b2b_bubbles: got %0d idle cycles want 0", bubbles); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d beats missing want 0", exp_q.size()); end
  endtask
  task automatic test_stall;
    logic stop = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0, xr;
    logic [W-1:0]  pd = '0;
    logic [KW-1:0] pk = '0;
    logic [UW-1:0] pu = '0;
    sync;
    out_tready = 1'b1;
    fork
      begin
        push_db(32'h201, 32'h202, K1, K1, 1'b0);
        push_db(32'h203, 32'h204, K1, {KW/2{2'b01}}, 1'b1);
        push_db(32'h205, 32'h0, K1, K0, 1'b1);
        push_db(32'h207, 32'h208, {KW/2{2'b10}}, K1, 1'b1);
        idle;
        wait_drain;
        repeat (2) @(posedge aclk);
        stop = 1'b1;
      end
      while (!stop) begin
        @(posedge aclk);
        #1 out_tready = ~out_tready;
      end
      while (!stop) begin
        @(negedge aclk);
        if (pv && !pr) begin
          checks++;
          if (!out_tvalid || {out_tdata, out_tkeep, out_tuser, out_tlast} !== {pd, pk, pu, pl}) begin
            errors++;
            $display("FAIL stall_stable: got valid=%b data=%h want valid=1 data=%h", out_tvalid, out_tdata[31:0], pd[31:0]);
          end
        end
        xr = !out_tvalid || (out_tready && exp_q.size() > 0 && exp_q[0].f);
        checks++;
        if (in_tready !== xr) begin
          errors++;
          $display("FAIL stall_ready: got in_tready=%b want %b", in_tready, xr);
        end
        pv = out_tvalid; pr = out_tready; pd = out_tdata; pk = out_tkeep; pu = out_tuser; pl = out_tlast;
      end
    join
    out_tready = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d beats missing want 0", exp_q.size()); end
  endtask
  task automatic test_reset_mid;
    sync;
    out_tready = 1'b0;
    push_db(32'h55, 32'h66, K1, K1, 1'b1);
    idle;
    out_tready = 1'b1;
    @(posedge aclk);
    #1 out_tready = 1'b0;
    @(negedge aclk);
    checks++;
    if (out_tvalid !== 1'b1 || out_tdata[31:0] !== 32'h66) begin
      errors++;
      $display("FAIL mid_high: got valid=%b data=%h want 1 00000066", out_tvalid, out_tdata[31:0]);
    end
    reset = 1'b1;
    @(posedge aclk);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    checks += 2;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_tvalid); end
    if (in_tready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", in_tready); end
    sync;
    out_tready = 1'b1;
    push_db(32'h77, 32'h88, K1, K1, 1'b1);
    idle;
    wait_drain;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain: %0d beats missing want 0", exp_q.size()); end
  endtask
  task automatic test_zero_keep;
    int cnt = 0;
    sync;
    out_tready = 1'b1;
    fork
      begin
        push_db(32'hAA, 32'hBB, K0, K0, 1'b1);
        idle;
      end
      repeat (8) begin
        @(negedge aclk);
        cnt += int'(out_tvalid);
      end
    join
    wait_drain;
    checks += 2;
    if (cnt != 1) begin errors++; $display("FAIL zero_keep_cycles: got %0d valid cycles want 1", cnt); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL zero_keep_drain: %0d beats missing want 0", exp_q.size()); end
  endtask
  initial begin
    reset = 1'b1;
    in_tdata = '0; in_tkeep = '0; in_tuser = '0; in_tlast = 1'b0; in_tvalid = 1'b0;
    out_tready = 1'b0;
    test_reset;
    test_four_beat;
    test_odd;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    test_zero_keep;
    repeat (3) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
